// File: rtl/matrix_scan_reader.sv
// Walks a ROWS x COLS matrix memory with one-cycle read latency and streams the elements out,
// tagged with their coordinates, through a 3-entry credit-managed buffer. MATRIX_SCAN_TRANSPOSE_EN adds column-major order.
module matrix_scan_reader #(
    parameter  int DATA_W = 8,
    parameter  int ROWS   = 4,
    parameter  int COLS   = 4,
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef MATRIX_SCAN_TRANSPOSE_EN
    input  logic              col_major,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ROW_W-1:0]  mem_row,
    output logic [COL_W-1:0]  mem_col,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic              out_last
);

    localparam int ENTRY_W = DATA_W + ROW_W + COL_W + 1;
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic                r_col_major;
    logic                r_done;

    logic                r_inflight;
    logic [ROW_W-1:0]    r_tag_row;
    logic [COL_W-1:0]    r_tag_col;
    logic                r_tag_last;

    logic [ENTRY_W-1:0]  r_fifo_mem [0:2];
    logic [1:0]          r_wr_ptr;
    logic [1:0]          r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_start_accept;
    logic                w_start_col_major;
    logic                w_last_issue;
    logic                w_rd_en;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_nonempty;
    logic [ENTRY_W-1:0]  w_head;
    logic [DATA_W-1:0]   w_head_data;
    logic [ROW_W-1:0]    w_head_row;
    logic [COL_W-1:0]    w_head_col;
    logic                w_head_last;
    logic [1:0]          w_wr_ptr_inc;
    logic [1:0]          w_rd_ptr_inc;

`ifdef MATRIX_SCAN_TRANSPOSE_EN
    assign w_start_col_major = col_major;
`else
    assign w_start_col_major = 1'b0;
`endif

    assign w_start_accept  = (r_state == S_IDLE) && start;
    assign w_last_issue    = (r_row == ROW_MAX) && (r_col == COL_MAX);
    assign w_fifo_nonempty = (r_count != 2'd0);

    // Credit counts only registered occupancy; a pop in the same cycle does not free a slot yet.
    assign w_rd_en = (r_state == S_SCAN) &&
                     (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd3);

    assign w_push = r_inflight;
    assign w_pop  = w_fifo_nonempty && out_ready;

    assign w_head = r_fifo_mem[r_rd_ptr];
    assign {w_head_data, w_head_row, w_head_col, w_head_last} = w_head;

    assign w_wr_ptr_inc = (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
    assign w_rd_ptr_inc = (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_col_major <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_SCAN;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_col_major <= w_start_col_major;
                    end
                end
                S_SCAN: begin
                    if (w_rd_en) begin
                        if (w_last_issue) begin
                            r_state <= S_DRAIN;
                            r_row   <= '0;
                            r_col   <= '0;
                        end else if (r_col_major) begin
                            if (r_row == ROW_MAX) begin
                                r_row <= '0;
                                r_col <= r_col + COL_W'(1);
                            end else begin
                                r_row <= r_row + ROW_W'(1);
                            end
                        end else begin
                            if (r_col == COL_MAX) begin
                                r_col <= '0;
                                r_row <= r_row + ROW_W'(1);
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag travels alongside the read so the returning data knows where it came from.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_tag_row  <= '0;
            r_tag_col  <= '0;
            r_tag_last <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_tag_row  <= r_row;
                r_tag_col  <= r_col;
                r_tag_last <= w_last_issue;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 2'd0;
        end else if (w_start_accept) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {mem_rd_data, r_tag_row, r_tag_col, r_tag_last};
        end
    end

    assign busy      = (r_state != S_IDLE) || r_done;
    assign done      = r_done;
    assign mem_rd_en = w_rd_en;
    assign mem_row   = r_row;
    assign mem_col   = r_col;

    assign out_valid = w_fifo_nonempty;
    assign out_data  = w_fifo_nonempty ? w_head_data : '0;
    assign out_row   = w_fifo_nonempty ? w_head_row  : '0;
    assign out_col   = w_fifo_nonempty ? w_head_col  : '0;
    assign out_last  = w_fifo_nonempty && w_head_last;

endmodule

// File: tb/tb_matrix_scan_reader.sv
// Bench for matrix_scan_reader: table of scan scenarios checked against a scoreboard queue,
// plus hand-written reset sequences. Build with MATRIX_SCAN_TRANSPOSE_EN to add the column-major case.
module tb_matrix_scan_reader;

    localparam int DATA_W = 8;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int N      = ROWS * COLS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
`ifdef MATRIX_SCAN_TRANSPOSE_EN
    logic              col_major = 1'b0;
`endif
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [1:0]        mem_row;
    logic [1:0]        mem_col;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_last;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] r;
        logic [1:0] c;
        logic       l;
    } elem_t;

    typedef struct {
        string      name;
        logic [3:0] rdy_pat;
        int         restart_cyc;
        logic       cm;
        int         exp_first;
        int         exp_done;
    } scan_vec_t;

    elem_t     sb[$];
    scan_vec_t vecs[$];

    always #5 clk = ~clk;

    // Matrix store with registered read: element (r,c) holds 16*r+c.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= {2'b00, mem_row, 2'b00, mem_col};
    end

    matrix_scan_reader #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
`ifdef MATRIX_SCAN_TRANSPOSE_EN
        .col_major(col_major),
`endif
        .busy(busy),
        .done(done),
        .mem_rd_en(mem_rd_en),
        .mem_row(mem_row),
        .mem_col(mem_col),
        .mem_rd_data(mem_rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_row(out_row),
        .out_col(out_col),
        .out_last(out_last)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_done"},      32'(done), 0);
        chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 0);
        chk({tag, "_mem_row"},   32'(mem_row), 0);
        chk({tag, "_mem_col"},   32'(mem_col), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"},  32'(out_data), 0);
        chk({tag, "_out_row"},   32'(out_row), 0);
        chk({tag, "_out_col"},   32'(out_col), 0);
        chk({tag, "_out_last"},  32'(out_last), 0);
        $display("[%0t] %s: outputs busy=%0b valid=%0b rd_en=%0b", $time, tag, busy, out_valid, mem_rd_en);
    endtask

    task automatic run_scan(input scan_vec_t v);
        int    cyc;
        int    first_cyc;
        int    done_cyc;
        int    done_cnt;
        int    pops;
        int    issued;
        int    over;
        int    r;
        int    c;
        logic  pv;
        logic  pr;
        elem_t prev;
        elem_t got;
        elem_t e;

        sb.delete();
        for (int idx = 0; idx < N; idx++) begin
            if (v.cm) begin
                r = idx % ROWS;
                c = idx / ROWS;
            end else begin
                r = idx / COLS;
                c = idx % COLS;
            end
            e.d = 8'(16 * r + c);
            e.r = 2'(r);
            e.c = 2'(c);
            e.l = (idx == N - 1);
            sb.push_back(e);
        end

        first_cyc = 0; done_cyc = 0; done_cnt = 0; pops = 0; issued = 0; over = 0;
        pv = 1'b0; pr = 1'b0; prev = '0;

        @(posedge clk); #1;
        cyc = 0;
        start = 1'b1;
        out_ready = v.rdy_pat[0];
`ifdef MATRIX_SCAN_TRANSPOSE_EN
        col_major = v.cm;
`endif
        while (cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == v.restart_cyc);
            out_ready = v.rdy_pat[cyc % 4];
`ifdef MATRIX_SCAN_TRANSPOSE_EN
            if (cyc == 4) col_major = ~col_major;
`endif
            @(negedge clk);
            got = {out_data, out_row, out_col, out_last};
            if (done_cyc != 0) begin
                chk("post_done_busy",  32'(busy), 0);
                chk("post_done_pulse", 32'(done), 0);
                chk("post_done_valid", 32'(out_valid), 0);
                if (cyc >= done_cyc + 3) break;
            end else begin
                chk("busy_window", 32'(busy), 1);
                if (pv && !pr) begin
                    chk("stall_valid", 32'(out_valid), 1);
                    chk("stall_head", 32'(got), 32'(prev));
                end
                if (!out_valid) chk("empty_fields_zero", 32'(got), 0);
                if (mem_rd_en && (issued - pops) >= 3) over++;
                if (mem_rd_en) issued++;
                if (out_valid && first_cyc == 0) first_cyc = cyc;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("extra_element", 32'(got), 32'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("element", 32'(got), 32'(e));
                    end
                    pops++;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                pv = out_valid;
                pr = out_ready;
                prev = got;
            end
        end
        out_ready = 1'b0;
        start = 1'b0;

        if (v.exp_first != 0) chk({v.name, "_first_valid_cycle"}, 32'(first_cyc), 32'(v.exp_first));
        if (v.exp_done != 0)  chk({v.name, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
        chk({v.name, "_done_pulses"}, 32'(done_cnt), 1);
        chk({v.name, "_elements"}, 32'(pops), 32'(N));
        chk({v.name, "_credit_overrun"}, 32'(over), 0);
        chk({v.name, "_scoreboard_left"}, 32'(sb.size()), 0);
        $display("[%0t] scan %s: elements=%0d first=%0d done=%0d", $time, v.name, pops, first_cyc, done_cyc);
    endtask

    initial begin
        vecs.push_back('{name: "rowmajor_full",  rdy_pat: 4'b1111, restart_cyc: 0, cm: 1'b0, exp_first: 3, exp_done: 19});
        vecs.push_back('{name: "ready_1001",     rdy_pat: 4'b1001, restart_cyc: 0, cm: 1'b0, exp_first: 3, exp_done: 0});
        vecs.push_back('{name: "restart_c5",     rdy_pat: 4'b1111, restart_cyc: 5, cm: 1'b0, exp_first: 3, exp_done: 19});
        vecs.push_back('{name: "ready_sparse",   rdy_pat: 4'b0100, restart_cyc: 0, cm: 1'b0, exp_first: 3, exp_done: 0});
`ifdef MATRIX_SCAN_TRANSPOSE_EN
        vecs.push_back('{name: "colmajor_full",  rdy_pat: 4'b1111, restart_cyc: 0, cm: 1'b1, exp_first: 3, exp_done: 19});
        vecs.push_back('{name: "colmajor_1001",  rdy_pat: 4'b1001, restart_cyc: 0, cm: 1'b1, exp_first: 3, exp_done: 0});
`endif

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle");

        for (int i = 0; i < vecs.size(); i++) begin
            run_scan(vecs[i]);
        end

        // Reset in the middle of a stalled scan, then a fresh scan must begin at (0,0).
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 7) begin
                @(negedge clk);
                chk("stall_full_valid", 32'(out_valid), 1);
                chk("stall_no_issue", 32'(mem_rd_en), 0);
                chk("stall_head_origin", 32'({out_data, out_row, out_col}), 0);
                $display("[%0t] stalled scan: valid=%0b rd_en=%0b", $time, out_valid, mem_rd_en);
            end
            if (cyc == 8) rst_n = 1'b0;
        end
        @(posedge clk); #1;
        check_all_zero("mid_scan_reset");
        rst_n = 1'b1;
        run_scan(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matrix_scan_reader.md
# matrix_scan_reader

Read-side sequencer for the 2-D register-array matrix memories in the design. On a start pulse it walks every element of a ROWS×COLS matrix, drives row/col read addresses into a memory with one-cycle registered read latency, and emits the elements as a valid/ready stream tagged with their coordinates and an end-of-matrix flag. It sits between a matrix store and any streaming consumer, and absorbs consumer backpressure without losing or duplicating elements.

## Interface
- DATA_W, 8, element width
- ROWS, 4, matrix rows (≥1)
- COLS, 4, matrix columns (≥1)
- ROW_W / COL_W, derived: max(1, clog2(ROWS)) / max(1, clog2(COLS)); not user-set
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- col_major  in  1  scan order select, present only with the macro (see Configuration)
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse after the final element handshake
- mem_rd_en  out  1  read strobe to matrix memory
- mem_row  out  ROW_W  read row address
- mem_col  out  COL_W  read column address
- mem_rd_data  in  DATA_W  memory read data, valid the cycle after mem_rd_en
- out_valid  out  1  stream data valid
- out_ready  in  1  consumer ready
- out_data  out  DATA_W  element value
- out_row / out_col  out  ROW_W / COL_W  coordinates of out_data
- out_last  out  1  marks element ROWS*COLS−1 of the scan

## Operation
- States: IDLE, SCAN (reads still to issue), DRAIN (all reads issued, waiting for buffer to empty).
- IDLE→SCAN when start=1; issue index, buffer, and in-flight flag are cleared on entry. start while busy is ignored.
- Read issue: mem_rd_en=1 when in SCAN and (fifo_count + inflight) < 3, using registered values (no same-cycle pop credit). mem_row/mem_col hold the address of the current issue index.
- Order: row-major (col increments fastest, row increments on col wrap COLS−1→0). Column-major with the macro: row fastest.
- After issuing index ROWS*COLS−1: SCAN→DRAIN.
- Capture: the cycle after mem_rd_en, mem_rd_data plus the issued row/col/last tag are pushed into a 3-entry FIFO. Capacity is guaranteed by the credit rule; overflow is impossible.
- Output: out_valid = FIFO non-empty; out_data/out_row/out_col/out_last present the head. Pop on out_valid & out_ready. Head fields stay stable while out_valid=1 and out_ready=0.
- DRAIN→IDLE on the handshake with out_last=1; done=1 in the following cycle, together with busy=1. busy drops the cycle after that.
- Reset (any state, including mid-scan): state=IDLE; FIFO, in-flight flag, and index are cleared; the pending memory return is discarded. Every output is 0 in the cycle after the reset edge: busy, done, mem_rd_en, mem_row, mem_col, out_valid, out_data, out_row, out_col, out_last.
- mem_row/mem_col reset to 0 and are don't-care when mem_rd_en=0. out_* fields are 0 when the FIFO is empty.

## Timing
- start is sampled at edge E0. mem_rd_en for (0,0) is high in cycle 1. Data is on mem_rd_data in cycle 2 and is out_valid in cycle 3 (3-cycle start-to-first-data).
- With out_ready held at 1, throughput is one element per cycle. For a 4×4 matrix, the last element is in cycle 18 and done is in cycle 19.
- Under backpressure there are at most 3 elements buffered/in flight, and issue stalls until a pop.
- ROWS=COLS=1: a single element with out_last=1. A scan goes SCAN→DRAIN in the first issue cycle.

## Configuration
- MATRIX_SCAN_TRANSPOSE_EN defined: the col_major port exists and is sampled with start. col_major=1 selects column-major order and is held for the whole scan; mid-scan changes are ignored.
- MATRIX_SCAN_TRANSPOSE_EN undefined: no col_major port, and order is always row-major.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, release → all outputs 0, busy=0. A start with no memory returns nothing (hold) → none.
- Memory holds value 16·row+col, out_ready=1, start → out_data sequence 0x00,0x01,0x02,0x03,0x10…0x33. First valid in cycle 3, out_last only on 0x33, done in cycle 19.
- Same scan, with out_ready toggling 1,0,0,1 → the identical 16-value sequence, no duplicates. The head stays stable during stalls, and mem_rd_en never causes more than 3 outstanding elements.
- Start pulsed again in cycle 5 of a scan → ignored. Exactly 16 elements and one done pulse.
- rst_n=0 in cycle 8 with out_ready=0 → outputs 0 next cycle. A new start then yields a full scan beginning at (0,0).
- With MATRIX_SCAN_TRANSPOSE_EN and col_major=1 → the sequence is 0x00,0x10,0x20,0x30,0x01…0x33, and out_row/out_col match each value.
